// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the ID-stage decoder / pipeline datapath and the
// hazard controller.
//   master : decoder/datapath side, drives ID fields, mem_ready, clr_cnt and
//            receives the stall/forward/flush controls and statistics.
//   slave  : hazard controller side (pipe_hazard_ctrl).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rn;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wreg;
  logic             id_m2reg;
  logic             id_wmem;
  logic             id_flush;
  logic             mem_ready;
  logic             clr_cnt;
  logic             wpcir;
  logic             bubble;
  logic             freeze;
  logic             if_flush_o;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_timeout;

  modport master (
    output id_rs, id_rt, id_rn, id_use_rs, id_use_rt, id_wreg, id_m2reg,
           id_wmem, id_flush, mem_ready, clr_cnt,
    input  wpcir, bubble, freeze, if_flush_o, fwda, fwdb, stall_cnt,
           flush_cnt, mem_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_rn, id_use_rs, id_use_rt, id_wreg, id_m2reg,
           id_wmem, id_flush, mem_ready, clr_cnt,
    output wpcir, bubble, freeze, if_flush_o, fwda, fwdb, stall_cnt,
           flush_cnt, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline.
// Keeps shadow EX/MEM destination records, produces operand forwarding
// selects, load-use stalls, gated IF flush, a whole-pipeline freeze while
// data memory is busy, a sticky memory-wait timeout and saturating
// stall/flush statistics.
// Ports:
//   clock  : pipeline clock, rising edge
//   resetn : asynchronous active-low reset
//   hz     : slave side of pipe_hazard_ctrl_if (ID fields, mem_ready,
//            clr_cnt in; wpcir, bubble, freeze, if_flush_o, fwda, fwdb,
//            stall_cnt, flush_cnt, mem_timeout out)
module pipe_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input logic                clock,
  input logic                resetn,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic {
    ST_RUN,
    ST_WAIT
  } state_t;

  localparam logic [15:0] MAX_WAIT_C = 16'(MAX_WAIT);

  // Shadow pipeline records
  logic       ewreg, em2reg, emem;
  logic [4:0] ern;
  logic       mwreg, mm2reg, mmem;
  logic [4:0] mrn;

  logic ex_a, ex_b, mem_a, mem_b;
  logic load_use, freeze;
  logic wpcir, bubble, if_flush_o;
  logic [1:0] fwda, fwdb;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        mem_timeout;

  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Matching: r0 never matches
  always_comb begin
    ex_a  = ewreg && (ern != 5'd0) && (ern == hz.id_rs) && hz.id_use_rs;
    ex_b  = ewreg && (ern != 5'd0) && (ern == hz.id_rt) && hz.id_use_rt;
    mem_a = mwreg && (mrn != 5'd0) && (mrn == hz.id_rs) && hz.id_use_rs;
    mem_b = mwreg && (mrn != 5'd0) && (mrn == hz.id_rt) && hz.id_use_rt;
  end

  // An EX match on a load falls through to the MEM checks; the stall
  // covers that cycle so the stale select is never consumed.
  always_comb begin
    fwda = 2'b00;
    if (ex_a && !em2reg)      fwda = 2'b01;
    else if (mem_a && mm2reg) fwda = 2'b11;
    else if (mem_a)           fwda = 2'b10;

    fwdb = 2'b00;
    if (ex_b && !em2reg)      fwdb = 2'b01;
    else if (mem_b && mm2reg) fwdb = 2'b11;
    else if (mem_b)           fwdb = 2'b10;
  end

  always_comb begin
    load_use   = (ex_a || ex_b) && em2reg;
    freeze     = mmem && !hz.mem_ready;
    wpcir      = 1'b1;
    bubble     = 1'b0;
    if_flush_o = hz.id_flush;
    if (freeze) begin
      wpcir      = 1'b0;
      if_flush_o = 1'b0;
    end else if (load_use) begin
      wpcir      = 1'b0;
      bubble     = 1'b1;
      if_flush_o = 1'b0;
    end
  end

  // Record pipeline
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ewreg  <= 1'b0;
      em2reg <= 1'b0;
      emem   <= 1'b0;
      ern    <= '0;
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mmem   <= 1'b0;
      mrn    <= '0;
    end else if (!freeze) begin
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      mmem   <= emem;
      mrn    <= ern;
      if (bubble) begin
        ewreg  <= 1'b0;
        em2reg <= 1'b0;
        emem   <= 1'b0;
        ern    <= '0;
      end else begin
        ewreg  <= hz.id_wreg;
        em2reg <= hz.id_m2reg;
        emem   <= hz.id_m2reg | hz.id_wmem;
        ern    <= hz.id_rn;
      end
    end
  end

  // Memory-wait FSM
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_RUN: begin
        if (freeze) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = 16'd1;
        end
      end
      ST_WAIT: begin
        if (hz.mem_ready) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt != '1) begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      mem_timeout <= 1'b0;
    else if (state == ST_WAIT && wait_cnt >= MAX_WAIT_C)
      mem_timeout <= 1'b1;
  end

  // Statistics; clear wins over a same-cycle increment
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (hz.clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (load_use && !freeze && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (if_flush_o && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.wpcir       = wpcir;
  assign hz.bubble      = bubble;
  assign hz.freeze      = freeze;
  assign hz.if_flush_o  = if_flush_o;
  assign hz.fwda        = fwda;
  assign hz.fwdb        = fwdb;
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;
  assign hz.mem_timeout = mem_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic clock;
  logic resetn;
  int unsigned n_total;
  int unsigned n_bad;

  pipe_hazard_ctrl_if #(.CNT_W(16)) hz_if ();

  pipe_hazard_ctrl #(.CNT_W(16), .MAX_WAIT(2)) dut (
    .clock  (clock),
    .resetn (resetn),
    .hz     (hz_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic id(input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] rn, input logic urs, input logic urt,
                    input logic w, input logic m2, input logic wm,
                    input logic fl);
    hz_if.id_rs     = rs;
    hz_if.id_rt     = rt;
    hz_if.id_rn     = rn;
    hz_if.id_use_rs = urs;
    hz_if.id_use_rt = urt;
    hz_if.id_wreg   = w;
    hz_if.id_m2reg  = m2;
    hz_if.id_wmem   = wm;
    hz_if.id_flush  = fl;
    #1;
  endtask

  task automatic ctl(input logic [31:0] wp, input logic [31:0] bu,
                     input logic [31:0] fz, input logic [31:0] fl);
    check("wpcir",  32'(hz_if.wpcir),      wp);
    check("bubble", 32'(hz_if.bubble),     bu);
    check("freeze", 32'(hz_if.freeze),     fz);
    check("iflush", 32'(hz_if.if_flush_o), fl);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    resetn  = 1'b0;
    hz_if.mem_ready = 1'b1;
    hz_if.clr_cnt   = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    ctl(1, 0, 0, 0);
    check("rst_fwda",  32'(hz_if.fwda), 0);
    check("rst_fwdb",  32'(hz_if.fwdb), 0);
    check("rst_stall", 32'(hz_if.stall_cnt), 0);
    check("rst_flush", 32'(hz_if.flush_cnt), 0);
    check("rst_tmo",   32'(hz_if.mem_timeout), 0);
    resetn = 1'b1;
    tick();

    // add r3 ; sub reads r3 -> EX forward
    id(1, 2, 3, 1, 1, 1, 0, 0, 0);
    check("add_fwda", 32'(hz_if.fwda), 0);
    tick();
    id(3, 4, 6, 1, 1, 1, 0, 0, 0);
    check("ex_fwd_a", 32'(hz_if.fwda), 1);
    check("ex_fwd_b", 32'(hz_if.fwdb), 0);
    ctl(1, 0, 0, 0);
    tick();

    // lw r5 ; add uses rt=r5 -> one stall then load forward
    id(1, 5, 5, 1, 0, 1, 1, 0, 0);
    ctl(1, 0, 0, 0);
    tick();
    id(1, 5, 8, 1, 1, 1, 0, 0, 0);
    ctl(0, 1, 0, 0);
    tick();
    check("lu_stall_cnt", 32'(hz_if.stall_cnt), 1);
    check("lu_fwdb", 32'(hz_if.fwdb), 3);
    check("lu_fwda", 32'(hz_if.fwda), 0);
    ctl(1, 0, 0, 0);
    tick();

    // add r7, two independents, reader -> no forward
    id(1, 2, 7, 1, 1, 1, 0, 0, 0); tick();
    id(1, 2, 9, 1, 1, 1, 0, 0, 0); tick();
    id(1, 2, 10, 1, 1, 1, 0, 0, 0); tick();
    id(7, 2, 0, 1, 1, 0, 0, 0, 0);
    check("far_fwda", 32'(hz_if.fwda), 0);
    ctl(1, 0, 0, 0);
    tick();
    // add r7, one independent, reader -> MEM alu forward
    id(1, 2, 7, 1, 1, 1, 0, 0, 0); tick();
    id(1, 2, 9, 1, 1, 1, 0, 0, 0); tick();
    id(7, 2, 0, 1, 1, 0, 0, 0, 0);
    check("mem_fwda", 32'(hz_if.fwda), 2);
    tick();

    // load into r0, reader of r0 -> nothing
    id(1, 0, 0, 1, 0, 1, 1, 0, 0); tick();
    id(0, 0, 11, 1, 1, 1, 0, 0, 0);
    check("r0_fwda", 32'(hz_if.fwda), 0);
    check("r0_fwdb", 32'(hz_if.fwdb), 0);
    ctl(1, 0, 0, 0);
    tick();
    // lui r2 ; reader of r2 -> load-class
    id(0, 2, 2, 0, 0, 1, 1, 0, 0); tick();
    id(2, 3, 11, 1, 1, 1, 0, 0, 0);
    ctl(0, 1, 0, 0);
    tick();
    check("lui_fwda", 32'(hz_if.fwda), 3);
    check("lui_stall_cnt", 32'(hz_if.stall_cnt), 2);
    ctl(1, 0, 0, 0);
    tick();

    // store reaches MEM, memory busy 3 cycles, flush request masked
    id(1, 4, 0, 1, 1, 0, 0, 1, 0); tick();
    id(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    hz_if.mem_ready = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 1);
    ctl(0, 0, 1, 0);
    tick();
    ctl(0, 0, 1, 0);
    check("wait_tmo1", 32'(hz_if.mem_timeout), 0);
    tick();
    ctl(0, 0, 1, 0);
    tick();
    hz_if.mem_ready = 1'b1;
    #1;
    ctl(1, 0, 0, 1);
    check("frz_stall_cnt", 32'(hz_if.stall_cnt), 2);
    check("frz_flush_cnt", 32'(hz_if.flush_cnt), 0);
    check("tmo_set", 32'(hz_if.mem_timeout), 1);
    tick();
    check("flush_cnt1", 32'(hz_if.flush_cnt), 1);
    check("tmo_sticky", 32'(hz_if.mem_timeout), 1);

    // flush plus load-use -> flush suppressed; then clear beats flush
    id(1, 5, 5, 1, 0, 1, 1, 0, 0); tick();
    id(5, 0, 0, 1, 0, 0, 0, 0, 1);
    ctl(0, 1, 0, 0);
    tick();
    check("lu_flush_cnt", 32'(hz_if.flush_cnt), 1);
    check("lu_stall_cnt3", 32'(hz_if.stall_cnt), 3);
    ctl(1, 0, 0, 1);
    check("br_fwda", 32'(hz_if.fwda), 3);
    hz_if.clr_cnt = 1'b1;
    tick();
    hz_if.clr_cnt = 1'b0;
    check("clr_flush", 32'(hz_if.flush_cnt), 0);
    check("clr_stall", 32'(hz_if.stall_cnt), 0);

    // reset pulsed in the middle of a memory wait
    id(1, 4, 0, 1, 1, 0, 0, 1, 0); tick();
    id(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    hz_if.mem_ready = 1'b0;
    #1;
    check("pre_rst_frz", 32'(hz_if.freeze), 1);
    tick();
    resetn = 1'b0;
    #1;
    ctl(1, 0, 0, 0);
    check("mid_rst_tmo", 32'(hz_if.mem_timeout), 0);
    check("mid_rst_fwda", 32'(hz_if.fwda), 0);
    #3;
    hz_if.mem_ready = 1'b1;
    resetn = 1'b1;
    tick();
    ctl(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline, sitting beside the ID-stage decoder. It keeps its own shadow copy of the destination info for the EX and MEM stages. From that it generates operand-forwarding selects, load-use stalls and IF flush gating. It freezes the whole pipeline while data memory is not ready and keeps saturating stall and flush statistics.

Parameters:
CNT_W, 16, width of the stall and flush statistic counters
MAX_WAIT, 255, number of consecutive memory-wait cycles after which mem_timeout is set (1..2^16-1)

Ports:
clock  in  1  pipeline clock, rising edge
resetn  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_rn  in  5  resolved destination register of the ID instruction (rd, rt or 31)
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_wreg  in  1  ID instruction writes the register file
id_m2reg  in  1  ID result comes from the memory path; treated as load-class, including lui
id_wmem  in  1  ID instruction is a store
id_flush  in  1  decoder request to flush IF (taken branch, j, jr)
mem_ready  in  1  data memory has completed the access in MEM this cycle
clr_cnt  in  1  synchronous clear of both statistic counters
wpcir  out  1  PC and IF/ID register write enable
bubble  out  1  force a NOP into the ID/EX register
freeze  out  1  hold every pipeline register
if_flush_o  out  1  gated IF flush
fwda  out  2  rs operand select: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data
fwdb  out  2  rt operand select, same encoding as fwda
stall_cnt  out  CNT_W  count of load-use stall cycles
flush_cnt  out  CNT_W  count of applied flushes
mem_timeout  out  1  sticky memory-wait timeout flag

Behaviour:
- Shadow records: EX = {ewreg, em2reg, emem, ern}; MEM = {mwreg, mm2reg, mmem, mrn}. mem-class flag = m2reg|wmem.
- Each clock edge with freeze=0: MEM <= EX. EX <= the ID record, or all-zero when bubble=1.
- Each clock edge with freeze=1: both records hold.
- Register r0 never matches. All matching and forwarding ignores destination 0.
- A match means: wreg=1, rn!=0, rn equals the source register, and the corresponding use bit is set.
- fwda priority:
  - EX match with em2reg=0 -> 01.
  - Otherwise MEM match with mm2reg=1 -> 11.
  - Otherwise MEM match with mm2reg=0 -> 10.
  - Otherwise 00.
- fwdb follows the same rules on id_rt/id_use_rt.
- A load-use condition exists when there is an EX match on rs or rt with em2reg=1.
- freeze = mmem & ~mem_ready. This is combinational, with no added latency.
- Output priority, freeze first:
  - freeze=1: wpcir=0, bubble=0, if_flush_o=0.
  - else load-use: wpcir=0, bubble=1, if_flush_o=0.
  - else: wpcir=1, bubble=0, if_flush_o=id_flush.
- Wait FSM, states RUN and WAIT, with a 16-bit wait_cnt:
  - RUN, freeze=1 -> WAIT, wait_cnt=1.
  - WAIT, mem_ready=1 -> RUN, wait_cnt=0.
  - WAIT, mem_ready=0 -> wait_cnt increments, saturating.
  - When wait_cnt reaches MAX_WAIT while in WAIT, mem_timeout is set. It clears only on reset.
- Counters:
  - stall_cnt increments on each cycle with load-use stall active and freeze=0.
  - flush_cnt increments on each cycle with if_flush_o=1.
  - Both saturate at all-ones.
  - clr_cnt=1 zeroes both and wins over a same-cycle increment.
- Asynchronous reset (resetn=0, at any time including mid-wait):
  - Both records clear, FSM goes to RUN, wait_cnt, counters and mem_timeout go to 0.
  - Outputs therefore settle to wpcir=1, bubble=0, freeze=0, if_flush_o=0, fwda=fwdb=00.

Test Plan:
- Reset release with idle ID, then `add r3` in ID followed by `sub` reading r3 -> cycle 2 fwda=01, wpcir=1, bubble=0.
- `lw r5`, then `add` using rt=r5 -> one cycle wpcir=0, bubble=1, stall_cnt=1. Next cycle fwdb=11, wpcir=1.
- `add r7` followed by two independent instructions and then a reader of r7 -> fwda=00. With only one intervening instruction -> fwda=10.
- Writer and reader both targeting r0 -> fwda=fwdb=00, no stall. `lui r2` then a reader of r2 -> treated as load: one stall, then fwd=11.
- Store in MEM with mem_ready=0 for 3 cycles -> freeze=1 for 3 cycles, records held, no counter change, id_flush masked. With MAX_WAIT=2 -> mem_timeout=1 stays set after mem_ready returns.
- id_flush=1 with no hazard -> if_flush_o=1, flush_cnt+1. Simultaneous load-use -> if_flush_o=0. clr_cnt=1 together with a flush -> flush_cnt=0. resetn pulsed low mid-WAIT -> all outputs return to reset values immediately.
